// File: rtl/joybus_txrx.sv
// joybus_txrx: single-wire GameCube/N64 (Joybus) transceiver.
// Sends a command of cmd_len bits MSB-first, appends the console stop bit,
// then captures up to rsp_len response bits with a no-edge timeout.
// Ports:
//   clk100mhz, reset_n   clock, async active-low reset
//   start                one-cycle request, honoured only when idle
//   cmd, cmd_len         right-justified command and its bit count
//   rsp_len              response bits to receive (0 = none)
//   data_in              raw pad level (asynchronous)
//   data_oe              1 = pull the open-drain line low
//   busy, done           transaction in flight / one-cycle end pulse
//   timeout              last transaction ran out of edges
//   rsp, rsp_count       captured bits (right-justified) and their count
module joybus_txrx #(
  parameter int TICKS_PER_QUARTER = 100,
  parameter int MAX_CMD_BITS      = 24,
  parameter int MAX_RSP_BITS      = 64,
  parameter int TIMEOUT_QUARTERS  = 64,
  localparam int CLW = $clog2(MAX_CMD_BITS + 1),
  localparam int RLW = $clog2(MAX_RSP_BITS + 1)
) (
  input  logic                    clk100mhz,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [MAX_CMD_BITS-1:0] cmd,
  input  logic [CLW-1:0]          cmd_len,
  input  logic [RLW-1:0]          rsp_len,
  input  logic                    data_in,
  output logic                    data_oe,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [MAX_RSP_BITS-1:0] rsp,
  output logic [RLW-1:0]          rsp_count
);
  localparam int TW = $clog2(TICKS_PER_QUARTER + 1);
  localparam int OW = $clog2(TIMEOUT_QUARTERS + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_QUARTER - 1);
  localparam logic [OW-1:0]  TO_LAST   = OW'(TIMEOUT_QUARTERS - 1);
  localparam logic [CLW-1:0] CMD_MAX   = CLW'(MAX_CMD_BITS);
  localparam logic [RLW-1:0] RSP_MAX   = RLW'(MAX_RSP_BITS);

  typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT} state_t;

  state_t                  state;
  logic [MAX_CMD_BITS-1:0] cmd_q;
  logic [CLW-1:0]          bit_idx;
  logic [RLW-1:0]          rsp_len_q;
  logic [TW-1:0]           tick;
  logic [1:0]              q;
  logic [OW-1:0]           tq;
  logic                    sync1, sync2, sync_d;
  logic [CLW-1:0]          cmd_len_c;
  logic [RLW-1:0]          rsp_len_c;
  logic                    quarter_end, fall, cur_bit;

  assign cmd_len_c   = (cmd_len > CMD_MAX) ? CMD_MAX : cmd_len;
  assign rsp_len_c   = (rsp_len > RSP_MAX) ? RSP_MAX : rsp_len;
  assign quarter_end = (tick == TICK_LAST);
  assign fall        = sync_d & ~sync2;
  assign cur_bit     = cmd_q[bit_idx];

  // Synchroniser resets to the idle (high) line level so no false edge
  // is seen coming out of reset.
  always_ff @(posedge clk100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= data_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  always_ff @(posedge clk100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      bit_idx   <= '0;
      rsp_len_q <= '0;
      tick      <= '0;
      q         <= '0;
      tq        <= '0;
      data_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      rsp       <= '0;
      rsp_count <= '0;
    end else begin
      done <= 1'b0;
      // Quarter timer free-runs while busy; state entries below restart it.
      if (state != IDLE) tick <= quarter_end ? '0 : tick + 1'b1;
      case (state)
        IDLE: if (start) begin
          cmd_q     <= cmd;
          rsp_len_q <= rsp_len_c;
          bit_idx   <= cmd_len_c - 1'b1;
          rsp       <= '0;
          rsp_count <= '0;
          timeout   <= 1'b0;
          busy      <= 1'b1;
          data_oe   <= 1'b1;        // every bit, stop included, starts low
          tick      <= '0;
          q         <= '0;
          state     <= (cmd_len_c == '0) ? TX_STOP : TX_BIT;
        end
        TX_BIT: if (quarter_end) begin
          q <= q + 1'b1;
          if (q == 2'd3) begin
            data_oe <= 1'b1;
            if (bit_idx == '0) state <= TX_STOP;
            else               bit_idx <= bit_idx - 1'b1;
          end else begin
            // '1' releases after quarter 0, '0' holds through quarter 2
            data_oe <= ~cur_bit && (q != 2'd2);
          end
        end
        TX_STOP: if (quarter_end) begin
          data_oe <= 1'b0;
          q       <= q + 1'b1;
          // Listen right after the low quarter so a fast responder is not
          // missed; with nothing to receive, pad out a full bit period so
          // back-to-back commands keep their spacing.
          if (q == 2'd0 && rsp_len_q != '0) begin
            state <= RX_WAIT;
            tq    <= '0;
          end else if (q == 2'd3) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        RX_WAIT: begin
          // The edge detector needs a high cycle before a low one, which is
          // the "line high first" condition. An edge beats a same-cycle timeout.
          if (fall) begin
            tick  <= '0;
            q     <= '0;
            state <= RX_BIT;
          end else if (quarter_end) begin
            if (tq == TO_LAST) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              tq <= tq + 1'b1;
            end
          end
        end
        RX_BIT: if (quarter_end) begin
          q <= q + 1'b1;
          if (q == 2'd1) begin     // two quarters after the detected edge
            rsp       <= {rsp[MAX_RSP_BITS-2:0], sync2};
            rsp_count <= rsp_count + 1'b1;
            if ((rsp_count + 1'b1) == rsp_len_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              tq    <= '0;
              state <= RX_WAIT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
